dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h01000000: byte address of memory word 0.
REQ-002 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words; SHALL be a power of two.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and access.
REQ-004 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req_valid, input, 1: initiator presents a request.
REQ-007 Port req_ready, output, 1: responder can accept a request this cycle.
REQ-008 Port read_write, input, 1: 0 = load, 1 = store.
REQ-009 Port address, input, 32: byte address.
REQ-010 Port data_in, input, 32: store data, right-aligned.
REQ-011 Port access_size, input, 3: RV32I func3 of the load/store.
REQ-012 Port resp_valid, output, 1: one-cycle response/acknowledge strobe.
REQ-013 Port data_out, output, 32: load result, valid while resp_valid is high.
REQ-014 Port err, output, 1: access rejected, valid while resp_valid is high.

Function
REQ-015 FSM states are IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance occurs on a rising edge with IDLE and req_valid=1; read_write, address, data_in, and access_size SHALL be latched at acceptance.
REQ-017 From IDLE: go to WAIT with the counter loaded to WAIT_CYCLES-1; go directly to RESP if WAIT_CYCLES=0.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP when the counter is 0; the access (memory read or write commit) SHALL occur on that transition.
REQ-019 resp_valid SHALL be high for exactly one cycle, in RESP, WAIT_CYCLES+1 cycles after the acceptance edge; RESP SHALL always return to IDLE, so back-to-back requests have a one-cycle IDLE gap.
REQ-020 Word index = (address-BASE_ADDR)>>2; storage is little-endian.
REQ-021 Loads: func3 000 = LB sign-extended, 001 = LH sign-extended, 010 = LW, 100 = LBU zero-extended, 101 = LHU zero-extended; the byte/half lane is selected by address[1:0].
REQ-022 Stores: func3 000 = SB, 001 = SH, 010 = SW; only the addressed lanes SHALL be modified.
REQ-023 err=1, no memory change, and data_out=0 when any of these hold: halfword access with address[0]=1; word access with address[1:0]!=0; an undefined func3 (011, 110, 111, or store func3 >010); or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
REQ-024 Outside RESP, data_out and err SHALL be 0.
REQ-025 A store response SHALL return data_out=0, with err set per REQ-023.
REQ-026 req_valid while not in IDLE SHALL be ignored and not queued.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, resp_valid 0, data_out 0, err 0, and all latched request fields 0.
REQ-028 req_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-029 Reset asserted during WAIT SHALL abandon the transaction; a pending store SHALL NOT be committed.
REQ-030 Memory contents SHALL NOT be cleared by reset; they SHALL be zero at simulation start.

Configuration
REQ-031 Macro DMEM_WAIT_STATES_EN defined: WAIT state and counter present, and WAIT_CYCLES is honoured.
REQ-032 Macro DMEM_WAIT_STATES_EN undefined: WAIT state and counter SHALL be removed, WAIT_CYCLES is ignored, and acceptance always leads to RESP on the next edge (latency 1).

Verification
REQ-033 SW 32'hDEADBEEF at 32'h01000010, then LW at the same address -> resp_valid 3 cycles after each acceptance; data_out=32'hDEADBEEF; err=0.
REQ-034 SB 32'h00000080 at 32'h01000013, then LB and LBU at the same address -> data_out=32'hFFFFFF80 and 32'h00000080; LW at 32'h01000010 returns 32'h80ADBEEF.
REQ-035 LH at 32'h01000011, LW at 32'h01000012, and SW at 32'h00FFFFFC -> each gives err=1 and data_out=0; a following LW at 32'h01000010 is unchanged.
REQ-036 Hold req_valid high continuously -> acceptances spaced WAIT_CYCLES+2 cycles apart; req_ready is 0 in WAIT and RESP.
REQ-037 Issue SW 32'h12345678 at 32'h01000020 and assert reset one cycle after acceptance -> no resp_valid; a following LW at 32'h01000020 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data memory responder: one request at a time, response WAIT_CYCLES+1 cycles after acceptance (1 without DMEM_WAIT_STATES_EN).
// Backpressure: req_ready only in IDLE; requests presented while busy are dropped. Memory is not cleared by reset.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h01000000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        read_write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [2:0]  access_size,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  state_t      state_q, state_d;
  logic        do_access;
  logic        rw_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic [31:0] data_out_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the acceptance edge, so decode the live request in IDLE.
  logic        src_rw;
  logic [31:0] src_addr, src_wdata;
  logic [2:0]  src_size;
  assign src_rw    = (state_q == IDLE) ? read_write  : rw_q;
  assign src_addr  = (state_q == IDLE) ? address     : addr_q;
  assign src_wdata = (state_q == IDLE) ? data_in     : wdata_q;
  assign src_size  = (state_q == IDLE) ? access_size : size_q;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          size_ok;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   wr_word;

  assign offset   = src_addr - BASE_ADDR;
  assign in_range = (src_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx      = offset[AW+1:2];
  assign lane     = src_addr[1:0];
  assign rd_word  = mem[idx];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    size_ok = 1'b0;
    case (src_size)
      3'b000:  size_ok = 1'b1;
      3'b001:  size_ok = !lane[0];
      3'b010:  size_ok = (lane == 2'b00);
      3'b100:  size_ok = !src_rw;
      3'b101:  size_ok = !src_rw && !lane[0];
      default: size_ok = 1'b0;
    endcase
  end

  assign acc_err = !size_ok || !in_range;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = rd_word;
    case (src_size)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte_en picks which lanes land in the word.
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = src_wdata;
    case (src_size[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{src_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{src_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = src_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = byte_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    do_access = 1'b0;
`ifdef DMEM_WAIT_STATES_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef DMEM_WAIT_STATES_EN
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            do_access = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
`else
          state_d   = RESP;
          do_access = 1'b1;
`endif
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q      <= '0;
`endif
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q   <= cnt_d;
`endif
      if (state_q == IDLE && req_valid) begin
        rw_q    <= read_write;
        addr_q  <= address;
        wdata_q <= data_in;
        size_q  <= access_size;
      end
      if (do_access) begin
        err_q      <= acc_err;
        data_out_q <= (src_rw || acc_err) ? 32'h0 : load_data;
      end else begin
        err_q      <= 1'b0;
        data_out_q <= '0;
      end
    end
  end

  // The reset term keeps an abandoned store from committing on an edge that arrives while reset is held.
  always_ff @(posedge clock) begin
    if (do_access && src_rw && !acc_err && !reset) begin
      mem[idx] <= wr_word;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign data_out   = data_out_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int          DEPTH = 256;
  localparam int          WAITC = 2;
`ifdef DMEM_WAIT_STATES_EN
  localparam int LAT = WAITC + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        read_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [2:0]  access_size = '0;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .read_write(read_write), .address(address), .data_in(data_in), .access_size(access_size),
    .resp_valid(resp_valid), .data_out(data_out), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-granular view of the rules, independent of any lane-mask formulation.
  task automatic model(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       output logic e, output logic [31:0] q);
    longint a64 = longint'(a);
    int     nbytes;
    bit     legal, in_rng;
    int     idx, ln;
    logic [31:0] v;
    in_rng = (a64 >= longint'(BASE)) && (a64 < longint'(BASE) + 4 * DEPTH);
    case (f[1:0])
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
    legal = rw ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e = !in_rng || !legal || ((a % nbytes) != 0);
    q = '0;
    if (!e) begin
      idx = int'((a - BASE) >> 2);
      ln  = int'(a % 4);
      if (rw) begin
        for (int i = 0; i < nbytes; i++) mem_m[idx][8*(ln+i) +: 8] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mem_m[idx][8*(ln+i) +: 8];
        if (!f[2] && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f[2] && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
        q = v;
      end
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response pulse.
  task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     output logic [31:0] q, output logic e);
    logic        exp_e;
    logic [31:0] exp_q;
    int          n = 0;
    bit          got = 0;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clock);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    read_write = rw; address = a; data_in = d; access_size = f; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    model(rw, a, d, f, exp_e, exp_q);
    while (n < 20 && !got) begin
      @(negedge clock);
      n++;
      if (resp_valid) got = 1;
      else if (data_out !== 32'h0 || err !== 1'b0) chk("idle_outputs_zero", {data_out[31:1], err}, 32'h0);
    end
    chk("resp_latency", 32'(n), 32'(LAT));
    chk("resp_data", data_out, exp_q);
    chk("resp_err", {31'b0, err}, {31'b0, exp_e});
    q = data_out;
    e = err;
    @(negedge clock);
    chk("resp_one_cycle", {data_out[31:1], data_out[0] | resp_valid | err}, 32'h0);
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          ready_at[$];
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Reset behaviour
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    @(negedge clock);

    // Word store / load
    req(1'b1, 32'h01000010, 32'hDEADBEEF, 3'b010, q, e);
    chk("sw_store_data_zero", q, 32'h0);
    req(1'b0, 32'h01000010, 32'h0, 3'b010, q, e);
    chk("lw_deadbeef", q, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads
    req(1'b1, 32'h01000013, 32'h00000080, 3'b000, q, e);
    req(1'b0, 32'h01000013, 32'h0, 3'b000, q, e);
    chk("lb_sext", q, 32'hFFFFFF80);
    req(1'b0, 32'h01000013, 32'h0, 3'b100, q, e);
    chk("lbu_zext", q, 32'h00000080);
    req(1'b0, 32'h01000010, 32'h0, 3'b010, q, e);
    chk("lw_after_sb", q, 32'h80ADBEEF);

    // Rejected accesses leave memory alone
    req(1'b0, 32'h01000011, 32'h0, 3'b001, q, e);
    chk("lh_misaligned_err", {31'b0, e}, 32'd1);
    req(1'b0, 32'h01000012, 32'h0, 3'b010, q, e);
    chk("lw_misaligned_err", {31'b0, e}, 32'd1);
    req(1'b1, 32'h00FFFFFC, 32'hFFFFFFFF, 3'b010, q, e);
    chk("sw_below_base_err", {31'b0, e}, 32'd1);
    req(1'b1, 32'h01000010, 32'h11111111, 3'b011, q, e);
    chk("store_bad_func3_err", {31'b0, e}, 32'd1);
    req(1'b0, 32'h01000010, 32'h0, 3'b010, q, e);
    chk("lw_unchanged", q, 32'h80ADBEEF);

    // Top-of-memory boundary
    req(1'b1, BASE + 32'h3FC, 32'hCAFEF00D, 3'b010, q, e);
    chk("sw_top_ok", {31'b0, e}, 32'd0);
    req(1'b0, BASE + 32'h400, 32'h0, 3'b010, q, e);
    chk("lw_past_top_err", {31'b0, e}, 32'd1);
    req(1'b0, BASE + 32'h3FE, 32'h0, 3'b101, q, e);
    chk("lhu_top", q, 32'h0000CAFE);

    // req_valid held high: acceptances spaced LAT+1 cycles apart
    read_write = 1'b0; address = 32'h01000010; access_size = 3'b010; req_valid = 1'b1;
    for (int i = 0; i < 4 * (LAT + 1) + 1; i++) begin
      if (req_ready) ready_at.push_back(i);
      @(negedge clock);
    end
    req_valid = 1'b0;
    chk("held_accept_count", 32'(ready_at.size()), 32'd5);
    for (int i = 1; i < ready_at.size(); i++)
      chk("held_accept_spacing", 32'(ready_at[i] - ready_at[i-1]), 32'(LAT + 1));
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clock);
    @(negedge clock);

`ifdef DMEM_WAIT_STATES_EN
    // Reset during WAIT abandons the store
    read_write = 1'b1; address = 32'h01000020; data_in = 32'h12345678; access_size = 3'b010; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abandon_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    req(1'b0, 32'h01000020, 32'h0, 3'b010, q, e);
    chk("abandoned_store_absent", q, 32'h0);
`else
    // Memory survives reset
    req(1'b1, 32'h01000020, 32'h12345678, 3'b010, q, e);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    req(1'b0, 32'h01000020, 32'h0, 3'b010, q, e);
    chk("mem_kept_over_rst", q, 32'h12345678);
`endif

    // Randomized traffic, including out-of-range and boundary addresses
    for (int t = 0; t < 200; t++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = BASE + $urandom_range(0, 63);
      else if (r == 8) a = BASE - $urandom_range(1, 8);
      else             a = BASE + 32'd1020 + $urandom_range(0, 7);
      req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), q, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
